// File: rtl/io_tst_pkg.sv
// ---------------------------------------------------------------------------
// io_tst_pkg
// Shared types and constants for the IO test-path edge counter.
//   io_cnt_st_t : measurement FSM states (IDLE, ARM, RUN)
//   ARM_CYCLES  : cycles spent in ARM to flush the synchronisers
//   OUT_W       : width of each published per-lane count on CNT_OUT
// ---------------------------------------------------------------------------
package io_tst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } io_cnt_st_t;

    localparam int unsigned ARM_CYCLES = 3;
    localparam int unsigned OUT_W      = 32;

endpackage

// File: rtl/io_sync_edge.sv
// ---------------------------------------------------------------------------
// io_sync_edge
// Single-lane 2-FF synchroniser, delay stage and edge detector.
//   CLK     : system clock
//   RST     : synchronous active-high reset, clears all stages
//   io      : asynchronous input line
//   io_edge : one-cycle pulse per detected edge, 3 cycles after io moves
// Build option IO_EDGE_CNT_BOTH_EN: when defined, both rising and falling
// edges are reported; otherwise only rising edges.
// ---------------------------------------------------------------------------
module io_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic io,
    output logic io_edge
);

    logic sync1;
    logic sync2;
    logic dly;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= io;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

`ifdef IO_EDGE_CNT_BOTH_EN
    assign io_edge = sync2 ^ dly;
`else
    assign io_edge = sync2 & ~dly;
`endif

endmodule

// File: rtl/io_edge_cnt.sv
// ---------------------------------------------------------------------------
// io_edge_cnt
// Per-lane edge counter over a fixed gate window for the IO test path.
// Each lane is synchronised, edge-detected and counted while the FSM is in
// RUN; at each window end the counts are published together with a
// one-cycle CNT_VLD pulse.
//   CLK        : system clock (REG_BUS clock)
//   RST        : synchronous active-high reset
//   EN         : level, 1 = measure, 0 = idle
//   CLR        : one-cycle pulse, clears counts and restarts the window
//   IO_IN      : LANES asynchronous test inputs
//   CNT_OUT    : published counts, lane k at [32k+31:32k], zero-extended
//   CNT_SAT    : per-lane saturation flags, published with CNT_OUT
//   CNT_VLD    : one-cycle pulse when CNT_OUT/CNT_SAT update
//   WIN_ACTIVE : high while the FSM is in RUN
// Build option IO_EDGE_CNT_BOTH_EN: count both edges instead of rising only.
// ---------------------------------------------------------------------------
module io_edge_cnt
    import io_tst_pkg::*;
#(
    parameter int unsigned LANES      = 5,
    parameter int unsigned WIN_CYCLES = 100_000_000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   CLR,
    input  logic [LANES-1:0]       IO_IN,
    output logic [LANES*OUT_W-1:0] CNT_OUT,
    output logic [LANES-1:0]       CNT_SAT,
    output logic                   CNT_VLD,
    output logic                   WIN_ACTIVE
);

    localparam int unsigned      WIN_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int unsigned      ARM_W    = $clog2(ARM_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    io_cnt_st_t       state_q;
    io_cnt_st_t       state_d;
    logic [ARM_W-1:0] arm_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] run_q   [LANES];
    logic [CNT_W-1:0] run_inc [LANES];
    logic [LANES-1:0] sat_q;
    logic [LANES-1:0] sat_inc;
    logic [LANES-1:0] edges;
    logic             counting;
    logic             terminal;

    // -----------------------------------------------------------------------
    // Per-lane synchroniser and edge detect
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        io_sync_edge u_sync (
            .CLK     (CLK),
            .RST     (RST),
            .io      (IO_IN[k]),
            .io_edge (edges[k])
        );
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (EN) state_d = ARM;
            end
            ARM: begin
                if (!EN)                    state_d = IDLE;
                else if (arm_q == ARM_LAST) state_d = RUN;
            end
            RUN: begin
                if (!EN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (CLR) state_d = EN ? ARM : IDLE;
    end

    // An EN fall or CLR on the terminal cycle suppresses the publish.
    assign counting = (state_q == RUN) && EN && !CLR;
    assign terminal = counting && (win_q == WIN_LAST);

    // -----------------------------------------------------------------------
    // Saturating increment including the current cycle's edge; used both for
    // the running update and for the value published on the terminal cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            run_inc[k] = (edges[k] && (run_q[k] != CNT_MAX)) ? run_q[k] + CNT_W'(1) : run_q[k];
            sat_inc[k] = sat_q[k] | (run_inc[k] == CNT_MAX);
        end
    end

    // -----------------------------------------------------------------------
    // State and ARM flush counter
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            arm_q   <= '0;
        end else begin
            state_q <= state_d;
            // CLR re-enters ARM from the start, even when already in ARM.
            if ((state_q == ARM) && (state_d == ARM) && !CLR) arm_q <= arm_q + ARM_W'(1);
            else                                               arm_q <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Running counters, window counter and published outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            win_q   <= '0;
            sat_q   <= '0;
            CNT_OUT <= '0;
            CNT_SAT <= '0;
            CNT_VLD <= 1'b0;
            for (int unsigned k = 0; k < LANES; k++) run_q[k] <= '0;
        end else begin
            CNT_VLD <= 1'b0;
            if (CLR) begin
                win_q   <= '0;
                sat_q   <= '0;
                CNT_OUT <= '0;
                CNT_SAT <= '0;
                for (int unsigned k = 0; k < LANES; k++) run_q[k] <= '0;
            end else if (terminal) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    CNT_OUT[k*OUT_W +: OUT_W] <= OUT_W'(run_inc[k]);
                    run_q[k]                  <= '0;
                end
                CNT_SAT <= sat_inc;
                CNT_VLD <= 1'b1;
                sat_q   <= '0;
                win_q   <= '0;
            end else if (counting) begin
                run_q <= run_inc;
                sat_q <= sat_inc;
                win_q <= win_q + WIN_W'(1);
            end else begin
                // IDLE, ARM, or EN falling in RUN: published values hold.
                win_q <= '0;
                sat_q <= '0;
                for (int unsigned k = 0; k < LANES; k++) run_q[k] <= '0;
            end
        end
    end

    assign WIN_ACTIVE = (state_q == RUN);

endmodule

// File: tb/tb_io_edge_cnt.sv
// ---------------------------------------------------------------------------
// tb_io_edge_cnt
// Self-checking bench for io_edge_cnt. Two instances share all inputs: one
// with CNT_W=32 and one with CNT_W=4 for saturation. A reference model that
// works on cycle arithmetic (input history, arm countdown, window position,
// unbounded per-lane totals) predicts every output each cycle.
// Honours IO_EDGE_CNT_BOTH_EN for the expected edge rule.
// ---------------------------------------------------------------------------
module tb_io_edge_cnt;

    localparam int unsigned LANES = 5;
    localparam int          WIN   = 100;
`ifdef IO_EDGE_CNT_BOTH_EN
    localparam logic [31:0] SQ_EXP  = 32'd20;
    localparam logic [31:0] SAT_EXP = 32'd40;
`else
    localparam logic [31:0] SQ_EXP  = 32'd10;
    localparam logic [31:0] SAT_EXP = 32'd20;
`endif

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  EN;
    logic                  CLR;
    logic [LANES-1:0]      IO_IN;
    logic [LANES*32-1:0]   cnt_a, cnt_b;
    logic [LANES-1:0]      sat_a, sat_b;
    logic                  vld_a, vld_b, act_a, act_b;

    io_edge_cnt #(.LANES(LANES), .WIN_CYCLES(WIN), .CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .IO_IN(IO_IN),
        .CNT_OUT(cnt_a), .CNT_SAT(sat_a), .CNT_VLD(vld_a), .WIN_ACTIVE(act_a)
    );

    io_edge_cnt #(.LANES(LANES), .WIN_CYCLES(WIN), .CNT_W(4)) u_dut_sat (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .IO_IN(IO_IN),
        .CNT_OUT(cnt_b), .CNT_SAT(sat_b), .CNT_VLD(vld_b), .WIN_ACTIVE(act_b)
    );

    always #5 CLK = ~CLK;

    int n_run  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int               m_lead = -1;   // -1 idle, >0 arm cycles left, 0 running
    int               m_pos  = 0;    // run cycles elapsed in current window
    int               m_acc [LANES];
    int               m_out [LANES];
    bit               m_vld  = 1'b0;
    logic [LANES-1:0] h1 = '0, h2 = '0, h3 = '0;   // IO_IN seen 1,2,3 edges ago
    logic [LANES*32-1:0] exp_a = '0, exp_b = '0;
    logic [LANES-1:0]    exp_sat_b = '0;

    // stimulus state
    logic [LANES-1:0] rnd_mask = '0;
    int               hold [LANES];
    bit               sq_on = 1'b0, sat_on = 1'b0;
    int               sq_ph = 0, sat_ph = 0;

    task automatic model_step();
        logic [LANES-1:0] e;
        // A level seen two edges ago but not three edges ago is counted now.
`ifdef IO_EDGE_CNT_BOTH_EN
        e = h2 ^ h3;
`else
        e = h2 & ~h3;
`endif
        m_vld = 1'b0;
        if (RST) begin
            m_lead = -1; m_pos = 0;
            for (int k = 0; k < LANES; k++) begin m_acc[k] = 0; m_out[k] = 0; end
        end else if (CLR) begin
            m_lead = EN ? 3 : -1; m_pos = 0;
            for (int k = 0; k < LANES; k++) begin m_acc[k] = 0; m_out[k] = 0; end
        end else if (!EN) begin
            m_lead = -1; m_pos = 0;
            for (int k = 0; k < LANES; k++) m_acc[k] = 0;
        end else if (m_lead < 0) begin
            m_lead = 3;
        end else if (m_lead > 0) begin
            m_lead--;
        end else begin
            for (int k = 0; k < LANES; k++) m_acc[k] += int'(e[k]);
            m_pos++;
            if (m_pos == WIN) begin
                for (int k = 0; k < LANES; k++) begin m_out[k] = m_acc[k]; m_acc[k] = 0; end
                m_pos = 0;
                m_vld = 1'b1;
            end
        end
        if (RST) begin h1 = '0; h2 = '0; h3 = '0; end
        else begin h3 = h2; h2 = h1; h1 = IO_IN; end
        for (int k = 0; k < LANES; k++) begin
            exp_a[32*k +: 32] = 32'(m_out[k]);
            exp_b[32*k +: 32] = (m_out[k] >= 15) ? 32'd15 : 32'(m_out[k]);
            exp_sat_b[k]      = (m_out[k] >= 15);
        end
    endtask

    // One clock: model samples alongside the DUT, then inputs move at negedge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        for (int k = 0; k < LANES; k++) begin
            if (rnd_mask[k]) begin
                if (hold[k] == 0) begin
                    IO_IN[k] = ~IO_IN[k];
                    hold[k]  = $urandom_range(1, 6);
                end else begin
                    hold[k]--;
                end
            end
        end
        if (sq_on)  begin sq_ph  = (sq_ph + 1) % 10; IO_IN[0] = (sq_ph < 5);  end
        if (sat_on) begin sat_ph = (sat_ph + 1) % 5; IO_IN[4] = (sat_ph < 2); end
    endtask

    task automatic wait_vlds(input int cnt, input int bound, output bit ok);
        int seen = 0;
        for (int n = 0; n < bound && seen < cnt; n++) begin
            tick();
            if (m_vld) seen++;
        end
        ok = (seen == cnt);
    endtask

    task automatic wait_pos(input int p, input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound && !ok; n++) begin
            tick();
            ok = (m_lead == 0) && (m_pos == p);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1; EN = 1'b0; CLR = 1'b0;
        IO_IN = 5'b00100; rnd_mask = 5'b11011;
        for (int n = 0; n < 5; n++) begin
            tick();
            n_run++;
            if ({vld_a, act_a, sat_a, vld_b, act_b, sat_b} !== '0)
                begin n_fail++; $display("FAIL reset_flags: got %b want 0", {vld_a, act_a, sat_a, vld_b, act_b, sat_b}); end
            n_run++;
            if ({cnt_a, cnt_b} !== '0)
                begin n_fail++; $display("FAIL reset_cnt: got %h / %h want 0", cnt_a, cnt_b); end
        end
        RST = 1'b0;
        tick();
        n_run++;
        if ({vld_a, act_a, cnt_a} !== '0)
            begin n_fail++; $display("FAIL reset_idle: got vld=%b act=%b cnt=%h want 0", vld_a, act_a, cnt_a); end
    endtask

    task automatic test_square();
        int vlds = 0;
        bit done = 1'b0;
        IO_IN[0] = 1'b0; IO_IN[1] = 1'b0; rnd_mask = 5'b11000;
        sq_on = 1'b1; sq_ph = 0; EN = 1'b1;
        for (int n = 1; n <= 400 && !done; n++) begin
            tick();
            n_run++;
            if ({vld_a, act_a, sat_a} !== {m_vld, m_lead == 0, {LANES{1'b0}}})
                begin n_fail++; $display("FAIL sq_flags: got %b want %b", {vld_a, act_a, sat_a}, {m_vld, m_lead == 0, {LANES{1'b0}}}); end
            n_run++;
            if ({vld_b, act_b, sat_b} !== {m_vld, m_lead == 0, exp_sat_b})
                begin n_fail++; $display("FAIL sq_flags_sat: got %b want %b", {vld_b, act_b, sat_b}, {m_vld, m_lead == 0, exp_sat_b}); end
            n_run++;
            if ({cnt_a, cnt_b} !== {exp_a, exp_b})
                begin n_fail++; $display("FAIL sq_cnt: got %h / %h want %h / %h", cnt_a, cnt_b, exp_a, exp_b); end
            if (m_vld) begin
                vlds++;
                if (vlds == 1) begin
                    // First publish registers 103 edges after the edge that sampled EN.
                    n_run++;
                    if (n != 104) begin n_fail++; $display("FAIL sq_first_vld: got tick %0d want 104", n); end
                end
                n_run++;
                if (cnt_a[31:0] !== SQ_EXP) begin n_fail++; $display("FAIL sq_lane0: got %0d want %0d", cnt_a[31:0], SQ_EXP); end
                n_run++;
                if (cnt_a[63:32] !== 32'd0) begin n_fail++; $display("FAIL sq_lane1: got %0d want 0", cnt_a[63:32]); end
                n_run++;
                if (cnt_a[95:64] !== 32'd0) begin n_fail++; $display("FAIL arm_flush_lane2: got %0d want 0", cnt_a[95:64]); end
                if (vlds == 3) done = 1'b1;
            end
        end
        n_run++;
        if (!done) begin n_fail++; $display("FAIL sq_timeout: got %0d publishes want 3", vlds); end
    endtask

    task automatic test_boundary();
        bit ok;
        int vlds = 0;
        bit done = 1'b0;
        rnd_mask = 5'b10000; IO_IN[1] = 1'b0; IO_IN[3] = 1'b0;
        wait_vlds(2, 300, ok);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL bnd_wait_vld: got timeout want 2 publishes"); end
        // Sampled now, counted two edges later: on the terminal cycle.
        wait_pos(WIN - 3, 200, ok);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL bnd_wait_pos: got timeout want pos %0d", WIN - 3); end
        IO_IN[1] = 1'b1;
        tick();
        IO_IN[3] = 1'b1;
        for (int n = 0; n < 250 && !done; n++) begin
            tick();
            n_run++;
            if ({vld_a, act_a, cnt_a} !== {m_vld, m_lead == 0, exp_a})
                begin n_fail++; $display("FAIL bnd_model: got %b %b %h want %b %b %h", vld_a, act_a, cnt_a, m_vld, m_lead == 0, exp_a); end
            if (m_vld) begin
                vlds++;
                n_run++;
                if ({cnt_a[63:32], cnt_a[127:96]} !== ((vlds == 1) ? {32'd1, 32'd0} : {32'd0, 32'd1}))
                    begin n_fail++; $display("FAIL bnd_edge_w%0d: got lane1=%0d lane3=%0d", vlds, cnt_a[63:32], cnt_a[127:96]); end
                if (vlds == 2) done = 1'b1;
            end
        end
        n_run++;
        if (!done) begin n_fail++; $display("FAIL bnd_timeout: got %0d publishes want 2", vlds); end
    endtask

    task automatic test_clr();
        bit ok;
        bit done = 1'b0;
        rnd_mask = 5'b11010;
        wait_pos(50, 200, ok);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL clr_wait_pos: got timeout want pos 50"); end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        n_run++;
        if ({cnt_a, cnt_b, sat_a, sat_b, vld_a, vld_b, act_a} !== '0)
            begin n_fail++; $display("FAIL clr_clear: got cnt=%h/%h sat=%b/%b vld=%b act=%b want 0", cnt_a, cnt_b, sat_a, sat_b, vld_a, act_a); end
        for (int n = 2; n <= 200 && !done; n++) begin
            tick();
            n_run++;
            if ({vld_a, act_a, cnt_a, cnt_b, sat_b} !== {m_vld, m_lead == 0, exp_a, exp_b, exp_sat_b})
                begin n_fail++; $display("FAIL clr_model: got %b %b %h %h want %b %b %h %h", vld_a, act_a, cnt_a, cnt_b, m_vld, m_lead == 0, exp_a, exp_b); end
            if (m_vld) begin
                done = 1'b1;
                n_run++;
                if (n != 104) begin n_fail++; $display("FAIL clr_next_vld: got tick %0d want 104", n); end
            end
        end
        n_run++;
        if (!done) begin n_fail++; $display("FAIL clr_timeout: got no publish want 1"); end
    endtask

    task automatic test_en_fall();
        bit ok;
        logic [LANES*32-1:0] snap;
        wait_vlds(1, 200, ok);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL en_wait_vld: got timeout want 1 publish"); end
        snap = exp_a;
        wait_pos(40, 200, ok);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL en_wait_pos: got timeout want pos 40"); end
        EN = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            n_run++;
            if ({vld_a, act_a, vld_b, act_b} !== 4'b0000)
                begin n_fail++; $display("FAIL en_fall_flags: got %b want 0000", {vld_a, act_a, vld_b, act_b}); end
            n_run++;
            if ({cnt_a, cnt_b} !== {snap, exp_b})
                begin n_fail++; $display("FAIL en_fall_hold: got %h / %h want %h / %h", cnt_a, cnt_b, snap, exp_b); end
        end
        EN = 1'b1;
    endtask

    task automatic test_saturation();
        int vlds = 0;
        bit done = 1'b0;
        rnd_mask = 5'b01010; IO_IN[4] = 1'b0; sat_on = 1'b1; sat_ph = 0;
        for (int n = 0; n < 500 && !done; n++) begin
            tick();
            n_run++;
            if ({vld_b, act_b, sat_b, cnt_b} !== {m_vld, m_lead == 0, exp_sat_b, exp_b})
                begin n_fail++; $display("FAIL sat_model: got %b %b %b %h want %b %b %b %h", vld_b, act_b, sat_b, cnt_b, m_vld, m_lead == 0, exp_sat_b, exp_b); end
            if (m_vld) begin
                vlds++;
                if (vlds >= 2) begin
                    n_run++;
                    if ({cnt_b[159:128], sat_b[4]} !== {32'd15, 1'b1})
                        begin n_fail++; $display("FAIL sat_lane4: got cnt=%0d sat=%b want 15 1", cnt_b[159:128], sat_b[4]); end
                    n_run++;
                    if ({cnt_a[159:128], sat_a[4]} !== {SAT_EXP, 1'b0})
                        begin n_fail++; $display("FAIL sat_lane4_wide: got cnt=%0d sat=%b want %0d 0", cnt_a[159:128], sat_a[4], SAT_EXP); end
                end
                if (vlds == 3) done = 1'b1;
            end
        end
        n_run++;
        if (!done) begin n_fail++; $display("FAIL sat_timeout: got %0d publishes want 3", vlds); end
    endtask

    initial begin
        for (int k = 0; k < LANES; k++) begin
            hold[k] = 0; m_acc[k] = 0; m_out[k] = 0;
        end
        RST = 1'b1; EN = 1'b0; CLR = 1'b0; IO_IN = '0;
        test_reset();
        test_square();
        test_boundary();
        test_clr();
        test_en_fall();
        test_saturation();
        EN = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/io_edge_cnt.md
# io_edge_cnt

Per-lane rising-edge counter for the IO test path. It synchronises up to LANES asynchronous test inputs arriving from FPGA2 (GPIO 1V8 and LVDS test lines) and counts edges over a fixed gate window. At each window end it publishes one 32-bit count per lane. It sits directly upstream of the IO register block and drives its *_I_CNT inputs, which software reads over REG_BUS.

## Interface
- LANES, 5: number of monitored input lines.
- WIN_CYCLES, 100_000_000: gate window length in CLK cycles, ≥ 4.
- CNT_W, 32: per-lane counter width, ≤ 32. Counts are zero-extended to 32 bits on CNT_OUT.
- CLK  in  1  system clock, same clock as REG_BUS.
- RST  in  1  reset: one clock; reset is synchronous and active-high.
- EN  in  1  level; 1 = measure, 0 = idle.
- CLR  in  1  single-cycle pulse; clears counts and restarts the window.
- IO_IN  in  LANES  asynchronous test inputs.
- CNT_OUT  out  LANES*32  published counts; lane k occupies bits [32k+31:32k].
- CNT_SAT  out  LANES  per-lane saturation flag, published together with CNT_OUT.
- CNT_VLD  out  1  one-cycle pulse when CNT_OUT/CNT_SAT update.
- WIN_ACTIVE  out  1  high while in state RUN.

## Operation
- Per lane: 2-FF synchroniser, then a delay register, then edge = sync & ~dly.
- FSM states and transitions:
  - IDLE: entered from reset. Goes to ARM when EN=1.
  - ARM: runs 3 cycles to flush the synchroniser. Edges are ignored. Goes to RUN.
  - RUN: counting. Goes to IDLE when EN=0.
- Running counters run[k] are CNT_W bits wide and increment on each edge in RUN. They saturate at 2^CNT_W-1; once saturated they hold and set sat[k].
- Window counter win counts 0..WIN_CYCLES-1 in RUN. It is zero in all other states.
- Terminal cycle (RUN, win==WIN_CYCLES-1):
  - CNT_OUT[k] ← run[k] plus that cycle's edge, saturating.
  - CNT_SAT[k] ← sat[k] including that cycle's edge.
  - run, sat and win clear. The FSM stays in RUN.
- An edge on the terminal cycle belongs to the ending window. An edge on the cycle after belongs to the new window.
- CLR has priority over everything except RST:
  - CNT_OUT, CNT_SAT, run, sat and win clear.
  - No CNT_VLD pulse.
  - If EN=1 the FSM goes to ARM; otherwise it goes to IDLE.
- EN falling in RUN:
  - FSM goes to IDLE; run, sat and win clear.
  - CNT_OUT and CNT_SAT hold. No CNT_VLD pulse.
- Simultaneous EN fall and terminal cycle: the EN fall wins. No publish.
- Reset values:
  - CNT_OUT=0, CNT_SAT=0, CNT_VLD=0, WIN_ACTIVE=0.
  - FSM=IDLE; all synchroniser, delay, run and win registers 0.

## Timing
- IO_IN transition to counted edge: 3 CLK cycles (2 sync stages + 1 delay stage).
- EN rising edge to the first RUN cycle: 4 cycles (1 in IDLE + 3 in ARM). WIN_ACTIVE rises with RUN.
- First CNT_VLD pulse: the cycle after the WIN_CYCLES-th RUN cycle. Later pulses follow every WIN_CYCLES cycles.
- CNT_OUT changes in the same cycle that CNT_VLD=1 and is stable until the next publish, CLR or RST.
- Inputs must hold each level ≥ 2 CLK cycles to be counted. Shorter pulses may be missed.

## Configuration
- IO_EDGE_CNT_BOTH_EN:
  - Defined: edge = sync ^ dly, so both rising and falling edges count.
  - Undefined: rising edges only.
  - All timing and FSM behaviour is identical in both cases.

## Structure
- The package io_tst_pkg holds:
  - the state enum io_cnt_st_t {IDLE, ARM, RUN};
  - localparam ARM_CYCLES = 3;
  - localparam OUT_W = 32.
- One sub-module, io_sync_edge: a single-lane synchroniser + delay + edge detect with output edge. It honours IO_EDGE_CNT_BOTH_EN and is instantiated LANES times via generate.

## Test plan
- Reset: hold RST for 5 cycles with IO_IN toggling → all outputs 0, FSM in IDLE, no CNT_VLD.
- Square-wave count (WIN_CYCLES=100, EN=1, lane0 period 10 cycles, lane1 static 0) → CNT_VLD every 100 cycles. Lane0 reads 10, lane1 reads 0, CNT_SAT=0.
- ARM flush: lane2 held at 1 through reset and EN assertion → lane2 count 0 in the first window.
- Window boundary: a rising edge lands exactly on the terminal cycle → it counts in the ending window. An edge one cycle later counts in the next window.
- CLR and EN fall: CLR mid-window → CNT_OUT=0, no CNT_VLD, next CNT_VLD 103 cycles after CLR. EN fall mid-window → CNT_OUT holds its previous value, WIN_ACTIVE=0.
- Saturation and macro (CNT_W=4, 20 rising edges per window): CNT_OUT=15, CNT_SAT=1. With IO_EDGE_CNT_BOTH_EN, CNT_W=32 and the square-wave test → lane0 reads 20.
